// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, counter debouncer and edge
// detector for asynchronous pad inputs. Accepted edges raise sticky EVENT
// flags, which are cleared by writing 1 to CLR, and IRQ is the OR of the flags.
module input_conditioner #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] IN,
  input  logic         EN,
  input  logic [N-1:0] RISE_EN,
  input  logic [N-1:0] FALL_EN,
  input  logic [N-1:0] CLR,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic [N-1:0] EVENT,
  output logic         IRQ
);

  localparam int            CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [CW-1:0] cnt_q  [N];
  logic [N-1:0]  s;
  logic [N-1:0]  differ;
  logic [N-1:0]  flip;
  logic [N-1:0]  set;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift chain that retimes the raw inputs; it runs regardless of EN.
  // NOTE: sequential state uses <= so every stage samples its pre-edge value;
  // with = the chain would collapse into a single flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the chain is a register array, not a RAM, so it is cleared
      // on reset like any other state to avoid a stray edge after reset.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A channel flips when it has disagreed with LEVEL for DEBOUNCE cycles.
  always_comb begin
    // NOTE: defaults first so no path leaves a bit unassigned (no latch).
    differ = s ^ LEVEL;
    flip   = '0;
    set    = '0;
    for (int i = 0; i < N; i++) begin
      flip[i] = EN & differ[i] & (cnt_q[i] == CNT_MAX);
      set[i]  = flip[i] & ((s[i] & RISE_EN[i]) | (~s[i] & FALL_EN[i]));
    end
  end

  // Run-length counters of consecutive disagreeing cycles per channel.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (RESET || !EN || !differ[i] || cnt_q[i] == CNT_MAX) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounced level, single-cycle edge pulses and sticky event flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEVEL <= '0;
      RISE  <= '0;
      FALL  <= '0;
      EVENT <= '0;
    end else begin
      LEVEL <= LEVEL ^ flip;
      RISE  <= flip & s;
      FALL  <= flip & ~s;
      EVENT <= (EVENT & ~CLR) | set;
    end
  end

  assign IRQ = |EVENT;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed test of input_conditioner (N=4, 2 sync
// stages, debounce 4) against a behavioural model built from a delay queue
// and per-channel run lengths, plus hand-computed literal expectations.
module tb_input_conditioner;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [N-1:0] IN;
  logic         EN;
  logic [N-1:0] RISE_EN;
  logic [N-1:0] FALL_EN;
  logic [N-1:0] CLR;
  logic [N-1:0] LEVEL;
  logic [N-1:0] RISE;
  logic [N-1:0] FALL;
  logic [N-1:0] EVENT;
  logic         IRQ;

  int passed = 0;
  int total  = 0;

  input_conditioner #(.N(N), .SYNC_STAGES(SS), .DEBOUNCE(DB)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .EN(EN), .RISE_EN(RISE_EN),
    .FALL_EN(FALL_EN), .CLR(CLR), .LEVEL(LEVEL), .RISE(RISE),
    .FALL(FALL), .EVENT(EVENT), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Behavioural model: IN is seen SS edges late (delay queue); a level is
  // accepted after DB consecutive disagreeing samples while enabled.
  logic [N-1:0] hist [$];
  logic [N-1:0] m_level, m_rise, m_fall, m_event;
  int           run [N];

  task automatic model_step();
    logic [N-1:0] sv;
    logic [N-1:0] nxt;
    if (RESET) begin
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back('0);
      m_level = '0; m_rise = '0; m_fall = '0; m_event = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      sv = hist[0];
      hist.push_back(IN);
      void'(hist.pop_front());
      nxt = m_event & ~CLR;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        if (EN && sv[i] != m_level[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == DB) begin
            run[i] = 0;
            m_level[i] = sv[i];
            if (sv[i]) begin
              m_rise[i] = 1'b1;
              if (RISE_EN[i]) nxt[i] = 1'b1;
            end else begin
              m_fall[i] = 1'b1;
              if (FALL_EN[i]) nxt[i] = 1'b1;
            end
          end
        end else begin
          run[i] = 0;
        end
      end
      m_event = nxt;
    end
  endtask

  // Model advances on every rising edge using the inputs held across it.
  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Compare every output against the model 1 time unit after each edge.
  initial forever begin
    @(posedge CLK);
    #1;
    check("model_level", LEVEL, m_level);
    check("model_rise",  RISE,  m_rise);
    check("model_fall",  FALL,  m_fall);
    check("model_event", EVENT, m_event);
    check("model_irq",   IRQ,   |m_event);
  end

  // One clock edge; inputs are driven and literals checked 2 units after it.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  typedef struct { logic [N-1:0] val; int hold; } vec_t;
  vec_t vecs [6] = '{'{4'hF, 8}, '{4'h0, 8}, '{4'hA, 3},
                     '{4'h5, 8}, '{4'h0, 2}, '{4'hC, 8}};

  initial begin
    RESET = 1'b1; IN = 4'hF; EN = 1'b1;
    RISE_EN = 4'h1; FALL_EN = 4'h0; CLR = 4'h0;

    // Reset holds everything low even with all inputs high.
    repeat (2) begin
      step();
      check("rst_level", LEVEL, 4'h0);
      check("rst_rise",  RISE,  4'h0);
      check("rst_fall",  FALL,  4'h0);
      check("rst_event", EVENT, 4'h0);
      check("rst_irq",   IRQ,   1'b0);
    end
    IN = 4'h0; RESET = 1'b0;
    repeat (3) step();

    // Clean rise on channel 0: visible after SS+DB = 6 edges.
    IN[0] = 1'b1;
    repeat (5) step();
    check("rise0_early", LEVEL[0], 1'b0);
    step();
    check("rise0_level", LEVEL[0], 1'b1);
    check("rise0_pulse", RISE[0],  1'b1);
    check("rise0_event", EVENT[0], 1'b1);
    check("rise0_irq",   IRQ,      1'b1);
    step();
    check("rise0_pulse_end", RISE[0], 1'b0);

    // Glitch of 3 cycles is rejected; 4 cycles is accepted.
    IN[1] = 1'b1;
    repeat (3) step();
    IN[1] = 1'b0;
    repeat (8) step();
    check("glitch1_level", LEVEL[1], 1'b0);
    IN[1] = 1'b1;
    repeat (4) step();
    IN[1] = 1'b0;
    step();
    check("pulse1_early", LEVEL[1], 1'b0);
    step();
    check("pulse1_level", LEVEL[1], 1'b1);
    check("pulse1_rise",  RISE[1],  1'b1);
    repeat (8) step();

    // Masks: only the falling edge of channel 2 sets its flag.
    RISE_EN = 4'h0; FALL_EN = 4'h4; CLR = 4'hF;
    step();
    CLR = 4'h0;
    check("mask_cleared", EVENT, 4'h0);
    IN[2] = 1'b1;
    repeat (6) step();
    check("mask_rise2",  RISE[2],  1'b1);
    check("mask_noset2", EVENT[2], 1'b0);
    repeat (3) step();
    IN[2] = 1'b0;
    repeat (6) step();
    check("mask_fall2",  FALL[2], 1'b1);
    check("mask_event2", EVENT,   4'h4);
    check("mask_irq",    IRQ,     1'b1);
    step();
    check("mask_fall2_end", FALL[2], 1'b0);

    // Set and clear in the same cycle: set wins; a lone clear then wins.
    RISE_EN = 4'h1; FALL_EN = 4'h0; CLR = 4'hF;
    step();
    CLR = 4'h0;
    IN[0] = 1'b0;
    repeat (8) step();
    check("coll_fell0", LEVEL[0], 1'b0);
    check("coll_none",  EVENT,    4'h0);
    IN[0] = 1'b1;
    repeat (5) step();
    CLR = 4'h1;
    step();
    check("coll_rise0",  RISE[0],  1'b1);
    check("coll_setwin", EVENT[0], 1'b1);
    step();
    CLR = 4'h0;
    check("coll_cleared", EVENT[0], 1'b0);
    check("coll_irq",     IRQ,      1'b0);

    // EN low freezes channel 3; counting restarts fresh when re-enabled.
    EN = 1'b0; IN[3] = 1'b1;
    repeat (10) step();
    check("en_frozen3", LEVEL[3], 1'b0);
    EN = 1'b1;
    repeat (3) step();
    check("en_early3", LEVEL[3], 1'b0);
    step();
    check("en_level3", LEVEL[3], 1'b1);

    // Reset with the counter at 2 discards the partial count.
    IN[3] = 1'b0;
    repeat (8) step();
    check("rc_fell3", LEVEL[3], 1'b0);
    IN[3] = 1'b1;
    repeat (4) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("rc_level", LEVEL, 4'h0);
    check("rc_event", EVENT, 4'h0);
    check("rc_irq",   IRQ,   1'b0);
    repeat (5) step();
    check("rc_early3", LEVEL[3], 1'b0);
    step();
    check("rc_level3", LEVEL[3], 1'b1);

    // All channels switching together, including short glitches.
    RISE_EN = 4'hF; FALL_EN = 4'hF;
    foreach (vecs[v]) begin
      IN = vecs[v].val;
      repeat (vecs[v].hold) step();
    end
    repeat (8) step();
    check("multi_level", LEVEL, 4'hC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
